fdiv_arbiter: RTL and testbench

Shares one multi-cycle FPU unit (the `fdiv` divider, or any unit with the same order/accepted/done handshake) among `N_REQ` requesters. Grants are round-robin with one operation outstanding at a time. Operands are latched on grant, the unit is sequenced through its handshake, and the result is routed back to the granted requester with a one-cycle done pulse. Sits between the core's FPU issue ports and a single shared divider instance.

---
 rtl/fdiv_arbiter_if.sv | 17 +
 rtl/fdiv_arbiter.sv | 78 +++++++
 tb/tb_fdiv_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_arbiter_if.sv
// fdiv_arbiter_if: requester-side and shared-unit signals of fdiv_arbiter.
// The arbiter takes the slave view; requesters and the unit together form the master.
interface fdiv_arbiter_if #(parameter int N_REQ = 4);
   logic [N_REQ-1:0]    req_order, req_accepted, req_done;
   logic [32*N_REQ-1:0] req_rs1, req_rs2;
   logic [31:0]         req_rd, u_rs1, u_rs2, u_rd;
   logic                u_order, u_accepted, u_done, proto_err;
   logic [15:0]         last_latency;
   modport slave (
      input  req_order, req_rs1, req_rs2, u_accepted, u_done, u_rd,
      output req_accepted, req_done, req_rd, u_order, u_rs1, u_rs2, last_latency, proto_err
   );
   modport master (
      output req_order, req_rs1, req_rs2, u_accepted, u_done, u_rd,
      input  req_accepted, req_done, req_rd, u_order, u_rs1, u_rs2, last_latency, proto_err
   );
endinterface

// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: round-robin sharing of one multi-cycle FPU unit among N_REQ requesters,
// one operation outstanding, operands latched on grant and the result routed back.
module fdiv_arbiter #(parameter int N_REQ = 4) (
   input logic           clk,
   input logic           rstn,
   fdiv_arbiter_if.slave bus
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t           state;
   logic [IW-1:0]    ptr, idx, g;
   logic [15:0]      cnt, lat_q;
   logic [31:0]      rs1_q, rs2_q, rd_q;
   logic [N_REQ-1:0] done_q;
   logic             order_q, err_q;
   // descending scan so the lowest offset from ptr wins
   always_comb begin
      g = '0;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (bus.req_order[IW'((int'(ptr) + k) % N_REQ)]) g = IW'((int'(ptr) + k) % N_REQ);
   end
   assign bus.req_accepted = (state == IDLE && |bus.req_order) ? N_REQ'(1) << g : '0;
   assign bus.req_done     = done_q;
   assign bus.req_rd       = rd_q;
   assign bus.u_order      = order_q;
   assign bus.u_rs1        = rs1_q;
   assign bus.u_rs2        = rs2_q;
   assign bus.last_latency = lat_q;
   assign bus.proto_err    = err_q;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state   <= IDLE;
         ptr     <= '0;
         idx     <= '0;
         cnt     <= '0;
         lat_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         done_q  <= '0;
         order_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= '0;
         rd_q   <= '0;
         if (bus.u_done && state != WAIT) err_q <= 1'b1;
         case (state)
            IDLE: if (|bus.req_order) begin
               idx     <= g;
               ptr     <= g == IW'(N_REQ - 1) ? '0 : g + 1'b1;
               rs1_q   <= bus.req_rs1[{g, 5'd0} +: 32];
               rs2_q   <= bus.req_rs2[{g, 5'd0} +: 32];
               cnt     <= '0;
               order_q <= 1'b1;
               state   <= ISSUE;
            end
            ISSUE: begin
               cnt <= cnt + {15'd0, cnt != 16'hFFFF};
               if (bus.u_accepted) begin
                  order_q <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + {15'd0, cnt != 16'hFFFF};
               if (bus.u_done) begin
                  rd_q   <= bus.u_rd;
                  done_q <= N_REQ'(1) << idx;
                  state  <= RESP;
               end
            end
            default: begin
               lat_q <= cnt;
               state <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb_fdiv_arbiter: directed tests with a per-cycle reference model of the arbiter
// and a simple shared-unit model whose result is rs1 - rs2 + 0x3F800000.
module tb_fdiv_arbiter;
   localparam int N = 4;
   logic clk = 1'b0, rstn = 1'b1;
   int checks = 0, errors = 0;
   fdiv_arbiter_if #(.N_REQ(N)) bus();
   fdiv_arbiter #(.N_REQ(N)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;

   int cyc = 0, grant_cyc = 0, done_cyc = 0, ndone = 0, order_cycles = 0;
   logic [N-1:0] last_done = '0, rereq_mask = '0;
   logic [31:0] last_rd = '0, u_a = '0, u_b = '0;
   int rereq_left = 0, unit_lat = 5, unit_stall = 0, u_wait = 0, u_stall_cnt = 0;
   logic u_busy = 1'b0, spur = 1'b0;
   int grants[$];
   logic [N-1:0] dones[$];
   logic [31:0] rds[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // reference model: m_* describe the state after the coming edge
   logic m_busy = 0, m_acc = 0, m_resp = 0, m_err = 0;
   int m_ptr = 0, m_idx = 0, m_cnt = 0, m_lat = 0;
   logic [31:0] m_rs1 = 0, m_rs2 = 0, m_rd = 0;
   always @(negedge clk) begin
      int g;
      logic [N-1:0] ea;
      if (!rstn) begin
         m_busy = 0; m_acc = 0; m_resp = 0; m_err = 0; m_ptr = 0; m_idx = 0;
         m_cnt = 0; m_lat = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      end
      g  = rr_pick(bus.req_order, m_ptr);
      ea = (rstn && !m_busy && g >= 0) ? N'(1) << g : '0;
      chk("req_accepted", bus.req_accepted, ea);
      chk("acc_onehot", $onehot0(bus.req_accepted), 1);
      chk("req_done", bus.req_done, m_resp ? N'(1) << m_idx : '0);
      chk("req_rd", bus.req_rd, m_resp ? m_rd : 0);
      chk("u_order", bus.u_order, m_busy && !m_acc && !m_resp);
      chk("u_rs1", bus.u_rs1, m_rs1);
      chk("u_rs2", bus.u_rs2, m_rs2);
      chk("last_latency", bus.last_latency, m_lat);
      chk("proto_err", bus.proto_err, m_err);
      if (rstn) begin
         if (bus.u_done && !(m_busy && m_acc && !m_resp)) m_err = 1;
         if (m_resp) begin
            m_lat = m_cnt; m_busy = 0; m_resp = 0;
         end else if (m_busy) begin
            m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
            if (!m_acc) m_acc = bus.u_accepted;
            else if (bus.u_done) begin
               m_resp = 1;
               m_rd = m_rs1 - m_rs2 + 32'h3F80_0000;
            end
         end else if (g >= 0) begin
            m_busy = 1; m_acc = 0; m_cnt = 0; m_idx = g; m_ptr = (g + 1) % N;
            m_rs1 = bus.req_rs1[32*g +: 32];
            m_rs2 = bus.req_rs2[32*g +: 32];
         end
      end
   end

   // one clock of requesters and unit; called at posedge+1, returns at next posedge+1
   task automatic step();
      logic [N-1:0] acc;
      #2;
      acc = bus.req_accepted;
      if (bus.u_order) order_cycles++;
      for (int i = 0; i < N; i++) if (acc[i]) begin grants.push_back(i); grant_cyc = cyc; end
      @(posedge clk);
      #1;
      cyc++;
      bus.req_order  = bus.req_order & ~acc;
      bus.u_accepted = 1'b0;
      bus.u_done     = spur;
      bus.u_rd       = 32'hDEAD_BEEF;
      spur = 1'b0;
      if (u_busy) begin
         u_wait++;
         if (u_wait == unit_lat) begin
            bus.u_done = 1'b1;
            bus.u_rd   = u_a - u_b + 32'h3F80_0000;
            u_busy     = 1'b0;
         end
      end else if (bus.u_order) begin
         if (u_stall_cnt == unit_stall) begin
            bus.u_accepted = 1'b1;
            u_busy = 1'b1; u_wait = 0; u_stall_cnt = 0;
            u_a = bus.u_rs1; u_b = bus.u_rs2;
         end else u_stall_cnt++;
      end
      if (bus.req_done != 0) begin
         ndone++; done_cyc = cyc; last_done = bus.req_done; last_rd = bus.req_rd;
         dones.push_back(bus.req_done); rds.push_back(bus.req_rd);
      end
      for (int i = 0; i < N; i++)
         if (bus.req_done[i] && rereq_mask[i] && rereq_left > 0) begin
            bus.req_order[i] = 1'b1;
            rereq_left--;
         end
   endtask

   task automatic wait_done(input int n, input int budget);
      int b = 0;
      while (ndone < n && b < budget) begin step(); b++; end
      chk("done_count", ndone, n);
   endtask

   task automatic clear_logs();
      grants.delete(); dones.delete(); rds.delete();
      ndone = 0; order_cycles = 0;
   endtask

   task automatic do_reset();
      #1 rstn = 1'b0;
      bus.req_order = '0; bus.u_done = 1'b0; bus.u_accepted = 1'b0;
      u_busy = 1'b0; u_stall_cnt = 0; rereq_left = 0;
      #1;
      chk("rst_req_accepted", bus.req_accepted, 0);
      chk("rst_req_done", bus.req_done, 0);
      chk("rst_req_rd", bus.req_rd, 0);
      chk("rst_u_order", bus.u_order, 0);
      chk("rst_u_rs1", bus.u_rs1, 0);
      chk("rst_u_rs2", bus.u_rs2, 0);
      chk("rst_last_latency", bus.last_latency, 0);
      chk("rst_proto_err", bus.proto_err, 0);
      @(negedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   int exp_g3[6] = '{0, 2, 0, 2, 0, 2};
   logic [31:0] exp_rd2[4] = '{32'h4F90_1010, 32'h5FA0_2020, 32'h6FB0_3030, 32'h7FC0_4040};
   int t0;

   initial begin
      bus.req_order = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
      bus.u_accepted = 1'b0; bus.u_done = 1'b0; bus.u_rd = '0;
      do_reset();
      // single operation
      clear_logs();
      bus.req_rs1[31:0] = 32'h4040_0000;
      bus.req_rs2[31:0] = 32'h4000_0000;
      bus.req_order = 4'b0001;
      #1 chk("t1_grant", bus.req_accepted, 4'b0001);
      t0 = cyc;
      wait_done(1, 40);
      chk("t1_done", last_done, 4'b0001);
      chk("t1_done_cycle", done_cyc - t0, 7);
      chk("t1_rd", last_rd, 32'h3FC0_0000);
      chk("t1_order_cycles", order_cycles, 1);
      step();
      chk("t1_latency", bus.last_latency, 6);
      // all requesters at once after reset
      do_reset();
      clear_logs();
      bus.req_rs1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      bus.req_rs2 = {32'h0404_0404, 32'h0303_0303, 32'h0202_0202, 32'h0101_0101};
      bus.req_order = 4'b1111;
      wait_done(4, 80);
      chk("t2_grant_count", grants.size(), 4);
      for (int i = 0; i < 4; i++) if (i < grants.size()) chk("t2_grant", grants[i], i);
      for (int i = 0; i < 4; i++) if (i < dones.size()) begin
         chk("t2_done", dones[i], 4'b0001 << i);
         chk("t2_rd", rds[i], exp_rd2[i]);
      end
      step();
      // fairness between requesters 0 and 2
      clear_logs();
      rereq_mask = 4'b0101; rereq_left = 4;
      bus.req_order = 4'b0101;
      wait_done(6, 120);
      chk("t3_grant_count", grants.size(), 6);
      for (int i = 0; i < 6; i++) if (i < grants.size()) chk("t3_grant", grants[i], exp_g3[i]);
      rereq_mask = '0;
      step();
      // unit stall of three cycles
      clear_logs();
      unit_stall = 3;
      bus.req_rs1[63:32] = 32'h4040_0000;
      bus.req_rs2[63:32] = 32'h4000_0000;
      bus.req_order = 4'b0010;
      #1 chk("t4_grant", bus.req_accepted, 4'b0010);
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_stall_order", bus.u_order, 1);
         chk("t4_stall_rs1", bus.u_rs1, 32'h4040_0000);
         chk("t4_stall_rs2", bus.u_rs2, 32'h4000_0000);
      end
      chk("t4_no_done", ndone, 0);
      wait_done(1, 40);
      chk("t4_done_cycle", done_cyc - t0, 10);
      chk("t4_rd", last_rd, 32'h3FC0_0000);
      step();
      chk("t4_latency", bus.last_latency, 9);
      unit_stall = 0;
      // spurious u_done while idle
      clear_logs();
      spur = 1'b1;
      step();
      step();
      chk("t5_proto_err", bus.proto_err, 1);
      chk("t5_no_done", ndone, 0);
      bus.req_rs1[95:64] = 32'h4040_0000;
      bus.req_rs2[95:64] = 32'h4000_0000;
      bus.req_order = 4'b0100;
      wait_done(1, 40);
      chk("t5_done", last_done, 4'b0100);
      chk("t5_rd", last_rd, 32'h3FC0_0000);
      step();
      chk("t5_proto_err_sticky", bus.proto_err, 1);
      // reset while waiting on the unit
      clear_logs();
      unit_lat = 20;
      bus.req_order = 4'b0010;
      repeat (4) step();
      do_reset();
      unit_lat = 5;
      bus.req_rs1[127:96] = 32'h4040_0000;
      bus.req_rs2[127:96] = 32'h4000_0000;
      bus.req_order = 4'b1000;
      #1 chk("t6_grant", bus.req_accepted, 4'b1000);
      wait_done(1, 40);
      chk("t6_done", last_done, 4'b1000);
      chk("t6_rd", last_rd, 32'h3FC0_0000);
      step();
      chk("t6_latency", bus.last_latency, 6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
